// File: rtl/uart_rx_to_64.sv
// 8N1 UART receiver that packs eight consecutive good bytes into one 64-bit word.
// First byte lands in [7:0]; a bad stop bit or a long idle gap discards the partial word.
module uart_rx_to_64 #(
  parameter int CLK_F        = 50_000_000,
  parameter int UART_BPS     = 115200,
  parameter int CLK_GOAL     = CLK_F / UART_BPS,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [63:0] data_64,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CNT_W    = $clog2(CLK_GOAL + 1);
  localparam int IDLE_MAX = TIMEOUT_BITS * CLK_GOAL;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLK_GOAL / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_GOAL - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_rxd_s1;
  logic               r_rxd_s2;
  logic               r_rxd_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_bit_idx;
  logic [2:0]         r_byte_cnt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [7:0]         r_shift;
  logic [55:0]        r_lanes;
  logic [63:0]        r_data_64;
  logic               r_data_valid;
  logic               r_frame_err;

  logic               w_start_edge;
  logic               w_cnt_half;
  logic               w_cnt_last;
  logic               w_bit_tick;
  logic               w_stop_tick;
  logic               w_busy;

  // r_rxd_d is the previous synchronized sample, used only for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
    end
  end

  assign w_start_edge = (r_state == S_IDLE) && r_rxd_d && !r_rxd_s2;
  assign w_cnt_half   = (r_cnt == CNT_HALF);
  assign w_cnt_last   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_next = S_START;
      S_START: if (w_cnt_half) w_next = r_rxd_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_cnt_last && (r_bit_idx == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_cnt_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_bit_tick  = (r_state == S_DATA) && w_cnt_last;
    w_stop_tick = (r_state == S_STOP) && w_cnt_last;
    w_busy      = (r_state != S_IDLE) || (r_byte_cnt != 3'd0);
  end

  // Bit timing, byte assembly and word packing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_byte_cnt   <= 3'd0;
      r_idle_cnt   <= '0;
      r_data_64    <= 64'd0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;

      if ((r_state == S_IDLE) || (w_next != r_state) || w_cnt_last) r_cnt <= '0;
      else                                                          r_cnt <= r_cnt + 1'b1;

      if (r_state == S_START) r_bit_idx <= 3'd0;
      else if (w_bit_tick) begin
        r_shift   <= {r_rxd_s2, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if (w_stop_tick) begin
        if (r_rxd_s2) begin
          r_byte_cnt <= r_byte_cnt + 3'd1;
          if (r_byte_cnt == 3'd7) begin
            r_data_64    <= {r_shift, r_lanes};
            r_data_valid <= 1'b1;
          end else begin
            r_lanes[{r_byte_cnt, 3'b000} +: 8] <= r_shift;
          end
        end else begin
          r_frame_err <= 1'b1;
          r_byte_cnt  <= 3'd0;
        end
      end

      // A partial word left idle too long is dropped without any pulse
      if ((r_state != S_IDLE) || (r_byte_cnt == 3'd0) || w_start_edge) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt == IDLE_LAST) begin
        r_idle_cnt <= '0;
        r_byte_cnt <= 3'd0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign data_64    = r_data_64;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = w_busy;

endmodule

// File: tb/tb_uart_rx_to_64.sv
// Directed bench for uart_rx_to_64 at 64 clocks per bit (6.4 MHz / 100 kbaud).
// Pulses are counted by a monitor; each step checks count deltas, the word and busy.
module tb_uart_rx_to_64;

  localparam int CG = 64;

  logic        clk;
  logic        rst;
  logic        uart_rxd;
  logic [63:0] data_64;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n_vld = 0;
  int n_ferr = 0;
  int n_both = 0;
  int v0;
  int f0;

  uart_rx_to_64 #(
    .CLK_F       (6_400_000),
    .UART_BPS    (100_000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .data_64   (data_64),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid === 1'b1) n_vld++;
      if (frame_err === 1'b1) n_ferr++;
      if (data_valid === 1'b1 && frame_err === 1'b1) n_both++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    repeat (CG) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) tick();
    check("reset_data_64", data_64, 64'd0);
    check("reset_data_valid", {63'd0, data_valid}, 64'd0);
    check("reset_frame_err", {63'd0, frame_err}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    repeat (2 * CG) tick();

    // Nominal word with the data_valid cycle pinned on the last byte
    v0 = n_vld; f0 = n_ferr;
    for (int i = 1; i <= 7; i++) send_byte(8'(i * 8'h11));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i >= 3 && i != 4 && i != 5 && i != 6 ? 1'b1 : 1'b0);
    uart_rxd = 1'b1;
    repeat (34) tick();
    check("nom_valid_early", {63'd0, data_valid}, 64'd0);
    tick();
    check("nom_valid_pulse", {63'd0, data_valid}, 64'd1);
    check("nom_word", data_64, 64'h8877665544332211);
    tick();
    check("nom_valid_after", {63'd0, data_valid}, 64'd0);
    repeat (CG - 36) tick();
    repeat (CG) tick();
    check("nom_valid_count", 64'(n_vld - v0), 64'd1);
    check("nom_ferr_count", 64'(n_ferr - f0), 64'd0);
    check("nom_busy_idle", {63'd0, busy}, 64'd0);

    // Short low glitch between bytes 2 and 3 must leave the partial word intact
    v0 = n_vld; f0 = n_ferr;
    send_byte(8'h31);
    send_byte(8'h32);
    uart_rxd = 1'b0;
    repeat (20) tick();
    uart_rxd = 1'b1;
    repeat (3 * CG) tick();
    check("glitch_busy_held", {63'd0, busy}, 64'd1);
    check("glitch_no_valid", 64'(n_vld - v0), 64'd0);
    check("glitch_no_ferr", 64'(n_ferr - f0), 64'd0);
    check("glitch_word_held", data_64, 64'h8877665544332211);
    for (int i = 3; i <= 8; i++) send_byte(8'(8'h30 + i));
    repeat (CG) tick();
    check("glitch_word", data_64, 64'h3837363534333231);
    check("glitch_valid_count", 64'(n_vld - v0), 64'd1);

    // Framing error on the third byte
    v0 = n_vld; f0 = n_ferr;
    send_byte(8'h51);
    send_byte(8'h52);
    send_frame(8'h53, 1'b0);
    uart_rxd = 1'b1;
    repeat (CG) tick();
    check("frame_ferr_count", 64'(n_ferr - f0), 64'd1);
    check("frame_no_valid", 64'(n_vld - v0), 64'd0);
    check("frame_busy_cleared", {63'd0, busy}, 64'd0);
    check("frame_word_held", data_64, 64'h3837363534333231);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    repeat (CG) tick();
    check("frame_word", data_64, 64'hA7A6A5A4A3A2A1A0);
    check("frame_valid_count", 64'(n_vld - v0), 64'd1);
    check("frame_ferr_total", 64'(n_ferr - f0), 64'd1);

    // Break: line stuck low reports once, then nothing until it idles high
    v0 = n_vld; f0 = n_ferr;
    send_frame(8'h00, 1'b0);
    repeat (5 * CG) tick();
    uart_rxd = 1'b1;
    repeat (2 * CG) tick();
    check("break_ferr_once", 64'(n_ferr - f0), 64'd1);
    check("break_no_valid", 64'(n_vld - v0), 64'd0);
    check("break_busy", {63'd0, busy}, 64'd0);

    // Idle timeout drops a 3-byte partial word silently
    v0 = n_vld; f0 = n_ferr;
    send_byte(8'hE1);
    send_byte(8'hE2);
    send_byte(8'hE3);
    repeat (15 * CG) tick();
    check("timeout_busy_before", {63'd0, busy}, 64'd1);
    repeat (10 * CG) tick();
    check("timeout_busy_after", {63'd0, busy}, 64'd0);
    check("timeout_no_pulse", 64'((n_vld - v0) + (n_ferr - f0)), 64'd0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    repeat (CG) tick();
    check("timeout_word", data_64, 64'h0807060504030201);
    check("timeout_valid_count", 64'(n_vld - v0), 64'd1);

    // Reset in the middle of bit 4 of byte 5
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_byte(8'hC4);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    uart_rxd = 1'b0;
    repeat (CG / 2) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_word", data_64, 64'd0);
    rst = 1'b0;
    uart_rxd = 1'b1;
    repeat (3 * CG) tick();
    v0 = n_vld; f0 = n_ferr;
    check("rst_after_busy", {63'd0, busy}, 64'd0);
    check("rst_after_word", data_64, 64'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hD0 + i));
    repeat (CG) tick();
    check("rst_word", data_64, 64'hD7D6D5D4D3D2D1D0);
    check("rst_valid_count", 64'(n_vld - v0), 64'd1);
    check("rst_ferr_count", 64'(n_ferr - f0), 64'd0);

    check("valid_ferr_overlap", 64'(n_both), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_to_64.md
UART_RX_TO_64 -- requirements
Module: uart_rx_to_64

Interface
REQ-001 SHALL provide parameter CLK_F, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter UART_BPS, default 115200, line baud rate.
REQ-003 SHALL provide parameter CLK_GOAL, default CLK_F / UART_BPS (434), clocks per bit.
REQ-004 SHALL provide parameter TIMEOUT_BITS, default 20, idle bit-times that abort a partial word.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge; the only clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port uart_rxd  input  1  asynchronous UART serial line, idle high.
REQ-008 SHALL have port data_64  output  64  assembled word; first received byte in [7:0], eighth byte in [63:56].
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse marking data_64 as newly updated.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE or 1-7 bytes are held.

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value.
REQ-013 SHALL detect a start edge as synchronized rxd going 1->0 while in IDLE.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; a baud counter cnt counts 0..CLK_GOAL-1.
REQ-015 IDLE->START on start edge, cnt cleared to 0.
REQ-016 In START, at cnt==CLK_GOAL/2-1 sample rxd: 0 -> DATA with cnt=0 and bit index=0; 1 -> IDLE (glitch rejected, no outputs change).
REQ-017 In DATA, at cnt==CLK_GOAL-1 shift sampled bit into the byte LSB-first; after bit 7 -> STOP with cnt=0.
REQ-018 In STOP, at cnt==CLK_GOAL-1 sample rxd and return to IDLE the next cycle, so a start edge arriving immediately afterwards is caught.
REQ-019 Stop sample 1: store the byte at lane byte_cnt (0..7) and increment byte_cnt; on lane 7, update data_64 with all 8 lanes, pulse data_valid the following cycle, and wrap byte_cnt to 0.
REQ-020 Stop sample 0: pulse frame_err for one cycle, discard the byte, and clear byte_cnt to 0; data_64 is unchanged and data_valid is not pulsed.
REQ-021 With byte_cnt!=0 in IDLE, an idle counter SHALL count clocks; at TIMEOUT_BITS*CLK_GOAL clocks it SHALL clear byte_cnt silently (no pulse). Any start edge clears the idle counter.
REQ-022 data_64 SHALL hold its value between data_valid pulses; data_valid and frame_err are never high together.
REQ-023 Latency: data_valid SHALL be high exactly 1 cycle after the stop-bit sample of the eighth byte.
REQ-024 The line held low (break) SHALL produce frame_err once per failed frame and no re-trigger until rxd returns high and falls again.

Reset
REQ-025 On rst high at a clock edge: FSM=IDLE, cnt=0, bit index=0, byte_cnt=0, idle counter=0, synchronizer=1, data_64=0, data_valid=0, frame_err=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte and partial word; after release, reception resumes on the next start edge.

Verification
REQ-027 Reset: hold rst 3 cycles with rxd=1 -> data_64=0, data_valid=0, frame_err=0, busy=0.
REQ-028 Nominal: send bytes 0x11,0x22,...,0x88 at 434 clk/bit, 1 stop bit, no gaps -> one data_valid pulse, data_64=0x8877665544332211, frame_err never high.
REQ-029 Glitch: rxd low for 100 clocks then high -> FSM back to IDLE, no pulses, byte_cnt unchanged; then 8 good bytes -> correct word.
REQ-030 Framing: 3rd byte with stop bit 0 -> one frame_err pulse, no data_valid; next 8 good bytes 0xA0..0xA7 -> data_64=0xA7A6A5A4A3A2A1A0.
REQ-031 Timeout: 3 bytes, then idle 25 bit-times, then bytes 0x01..0x08 -> data_64=0x0807060504030201, single data_valid.
REQ-032 Reset mid-operation: rst pulsed during bit 4 of byte 5 -> busy=0 next cycle, data_64 keeps its reset value 0; then 8 fresh bytes -> correct word.
